// File: rtl/tank_move_ctrl.sv
// Per-frame tank motion controller: key priority, clamped stepping, collision undo/block.
// Optional grid snap on axis-changing turns when TANK_GRID_ALIGN_EN is defined.
module tank_move_ctrl #(
  parameter int INITIAL_X = 280,
  parameter int INITIAL_Y = 400,
  parameter int SPEED     = 2,
  parameter int MIN_X     = 0,
  parameter int MAX_X     = 615,
  parameter int MIN_Y     = 0,
  parameter int MAX_Y     = 455,
  parameter int GRID      = 8
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        upKey,
  input  logic        rightKey,
  input  logic        downKey,
  input  logic        leftKey,
  input  logic        collision,
  output logic [10:0] topLeftX,
  output logic [10:0] topLeftY,
  output logic [1:0]  tankDir,
  output logic        moving
);

`ifdef TANK_GRID_ALIGN_EN
  localparam bit SNAP_EN = 1'b1;
`else
  localparam bit SNAP_EN = 1'b0;
`endif

  localparam logic [11:0] SPD  = 12'(SPEED);
  localparam logic [11:0] LO_X = 12'(MIN_X);
  localparam logic [11:0] HI_X = 12'(MAX_X);
  localparam logic [11:0] LO_Y = 12'(MIN_Y);
  localparam logic [11:0] HI_Y = 12'(MAX_Y);
  localparam logic [11:0] GR   = 12'(GRID);
  localparam logic [11:0] GR_H = 12'(GRID / 2);

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b11;

  typedef enum logic [1:0] {IDLE, MOVE, BLOCKED} state_t;

  state_t      state;
  logic        hit_flag;
  logic [1:0]  blocked_dir;
  logic [10:0] prev_x, prev_y;

  logic        key_valid;
  logic [1:0]  key_dir;
  logic        hit;
  logic [11:0] cur_x, cur_y, step_x, step_y, turn_x, turn_y;
  logic        step_nonzero;

  // Round to nearest multiple of GRID (ties up), then clamp into [lo, hi].
  function automatic logic [11:0] snap(input logic [11:0] v,
                                       input logic [11:0] lo,
                                       input logic [11:0] hi);
    logic [11:0] r;
    r = ((v + GR_H) / GR) * GR;
    if (r < lo)      r = lo;
    else if (r > hi) r = hi;
    return r;
  endfunction

  always_comb begin
    key_valid = upKey | rightKey | downKey | leftKey;
    if (upKey)         key_dir = DIR_UP;
    else if (rightKey) key_dir = DIR_RIGHT;
    else if (downKey)  key_dir = DIR_DOWN;
    else               key_dir = DIR_LEFT;
  end

  // A hit arriving on the frame pulse itself belongs to the ending frame.
  assign hit = hit_flag | collision;

  always_comb begin
    cur_x  = {1'b0, topLeftX};
    cur_y  = {1'b0, topLeftY};
    step_x = cur_x;
    step_y = cur_y;
    case (tankDir)
      DIR_UP:    step_y = (cur_y < LO_Y + SPD) ? LO_Y : cur_y - SPD;
      DIR_DOWN:  step_y = (cur_y + SPD > HI_Y) ? HI_Y : cur_y + SPD;
      DIR_LEFT:  step_x = (cur_x < LO_X + SPD) ? LO_X : cur_x - SPD;
      default:   step_x = (cur_x + SPD > HI_X) ? HI_X : cur_x + SPD;
    endcase
    step_nonzero = (step_x != cur_x) || (step_y != cur_y);
  end

  always_comb begin
    turn_x = cur_x;
    turn_y = cur_y;
    if (SNAP_EN && (tankDir[0] != key_dir[0])) begin
      if (key_dir[0]) turn_y = snap(cur_y, LO_Y, HI_Y);
      else            turn_x = snap(cur_x, LO_X, HI_X);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state       <= IDLE;
      hit_flag    <= 1'b0;
      blocked_dir <= DIR_UP;
      topLeftX    <= 11'(INITIAL_X);
      topLeftY    <= 11'(INITIAL_Y);
      prev_x      <= 11'(INITIAL_X);
      prev_y      <= 11'(INITIAL_Y);
      tankDir     <= DIR_UP;
      moving      <= 1'b0;
    end else if (startOfFrame) begin
      hit_flag <= 1'b0;
      moving   <= 1'b0;
      case (state)
        IDLE, MOVE: begin
          if (hit) begin
            topLeftX    <= prev_x;
            topLeftY    <= prev_y;
            blocked_dir <= tankDir;
            state       <= BLOCKED;
          end else if (!key_valid) begin
            state <= IDLE;
          end else if (key_dir != tankDir) begin
            tankDir  <= key_dir;
            topLeftX <= turn_x[10:0];
            topLeftY <= turn_y[10:0];
            state    <= MOVE;
          end else begin
            prev_x   <= topLeftX;
            prev_y   <= topLeftY;
            topLeftX <= step_x[10:0];
            topLeftY <= step_y[10:0];
            moving   <= step_nonzero;
            state    <= MOVE;
          end
        end
        BLOCKED: begin
          if (!key_valid) begin
            state <= IDLE;
          end else if (key_dir != blocked_dir) begin
            tankDir  <= key_dir;
            topLeftX <= turn_x[10:0];
            topLeftY <= turn_y[10:0];
            state    <= MOVE;
          end
        end
        default: state <= IDLE;
      endcase
    end else if (collision) begin
      hit_flag <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tank_move_ctrl.sv
// Directed bench for tank_move_ctrl: default instance plus a near-edge instance at (1,403).
// Expectations adapt when TANK_GRID_ALIGN_EN is defined.
module tb_tank_move_ctrl;

`ifdef TANK_GRID_ALIGN_EN
  localparam bit SNAP = 1'b1;
`else
  localparam bit SNAP = 1'b0;
`endif

  // X after the first right->up turn at X=284 (snaps to 288 with grid alignment)
  localparam int XB = SNAP ? 288 : 284;
  localparam int Y2 = SNAP ? 400 : 403;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic sof = 1'b0;
  logic col = 1'b0;
  logic col2 = 1'b0;
  logic [3:0] keys1 = '0;   // {up, right, down, left}
  logic [3:0] keys2 = '0;

  logic [10:0] x1, y1, x2, y2;
  logic [1:0]  d1, d2;
  logic        m1, m2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tank_move_ctrl dut (
    .clk(clk), .resetN(resetN), .startOfFrame(sof),
    .upKey(keys1[3]), .rightKey(keys1[2]), .downKey(keys1[1]), .leftKey(keys1[0]),
    .collision(col),
    .topLeftX(x1), .topLeftY(y1), .tankDir(d1), .moving(m1)
  );

  tank_move_ctrl #(.INITIAL_X(1), .INITIAL_Y(403), .SPEED(2)) dut_edge (
    .clk(clk), .resetN(resetN), .startOfFrame(sof),
    .upKey(keys2[3]), .rightKey(keys2[2]), .downKey(keys2[1]), .leftKey(keys2[0]),
    .collision(col2),
    .topLeftX(x2), .topLeftY(y2), .tankDir(d2), .moving(m2)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic frame(input logic [3:0] k1, input logic [3:0] k2, input logic hit_at_sof);
    @(negedge clk);
    keys1 = k1;
    keys2 = k2;
    sof   = 1'b1;
    col   = hit_at_sof;
    @(negedge clk);
    sof   = 1'b0;
    col   = 1'b0;
  endtask

  task automatic mid_hit();
    @(negedge clk);
    col = 1'b1;
    @(negedge clk);
    col = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic chk1(input string tag, input int ex, input int ey, input int ed, input int em);
    check({tag, ".x"}, int'(x1), ex);
    check({tag, ".y"}, int'(y1), ey);
    check({tag, ".dir"}, int'(d1), ed);
    check({tag, ".mov"}, int'(m1), em);
  endtask

  localparam logic [3:0] K_NONE = 4'b0000;
  localparam logic [3:0] K_UP   = 4'b1000;
  localparam logic [3:0] K_RT   = 4'b0100;
  localparam logic [3:0] K_DN   = 4'b0010;
  localparam logic [3:0] K_LT   = 4'b0001;

  initial begin
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    chk1("reset", 280, 400, 0, 0);
    check("reset2.x", int'(x2), 1);
    check("reset2.y", int'(y2), 403);

    frame(K_RT, K_NONE, 1'b0); chk1("turn_right", 280, 400, 1, 0);
    frame(K_RT, K_NONE, 1'b0); chk1("step_r1", 282, 400, 1, 1);
    frame(K_RT, K_NONE, 1'b0); chk1("step_r2", 284, 400, 1, 1);

    @(negedge clk); keys1 = K_UP;
    repeat (3) @(negedge clk);
    chk1("between_pulses", 284, 400, 1, 1);

    frame(K_UP, K_NONE, 1'b0); chk1("turn_up", XB, 400, 0, 0);
    frame(K_UP, K_NONE, 1'b0); chk1("step_up", XB, 398, 0, 1);
    mid_hit();
    check("hit_pending_hold.y", int'(y1), 398);
    frame(K_UP, K_NONE, 1'b0); chk1("restore", XB, 400, 0, 0);
    frame(K_UP, K_NONE, 1'b0); chk1("blocked_hold", XB, 400, 0, 0);
    frame(K_RT, K_NONE, 1'b0); chk1("unblock_turn", XB, 400, 1, 0);
    frame(K_RT, K_NONE, 1'b0); chk1("unblock_step", XB + 2, 400, 1, 1);

    frame(K_RT, K_NONE, 1'b1); chk1("sof_hit_restore", XB, 400, 1, 0);
    frame(K_RT, K_NONE, 1'b0); chk1("sof_hit_blocked", XB, 400, 1, 0);
    frame(K_DN, K_NONE, 1'b0); chk1("turn_down", XB, 400, 2, 0);
    frame(K_DN, K_NONE, 1'b0); chk1("step_down", XB, 402, 2, 1);

    frame(K_UP | K_LT, K_NONE, 1'b0); chk1("prio_up", XB, 402, 0, 0);
    frame(K_NONE, K_NONE, 1'b0);      chk1("idle1", XB, 402, 0, 0);
    frame(K_NONE, K_NONE, 1'b0);      chk1("idle2", XB, 402, 0, 0);

    // pending hit and motion discarded by a mid-frame reset
    mid_hit();
    @(negedge clk); resetN = 1'b0;
    @(negedge clk); resetN = 1'b1;
    chk1("reset_mid", 280, 400, 0, 0);
    frame(K_UP, K_NONE, 1'b0); chk1("post_reset_step", 280, 398, 0, 1);

    // edge instance: clamp at MIN_X without wrap, optional snap on turn
    frame(K_NONE, K_RT, 1'b0);
    check("edge_turn_r.dir", int'(d2), 1);
    check("edge_turn_r.y", int'(y2), Y2);
    check("edge_turn_r.x", int'(x2), 1);
    frame(K_NONE, K_LT, 1'b0);
    check("edge_turn_180.dir", int'(d2), 3);
    check("edge_turn_180.y", int'(y2), Y2);
    frame(K_NONE, K_LT, 1'b0);
    check("edge_step.x", int'(x2), 0);
    check("edge_step.mov", int'(m2), 1);
    frame(K_NONE, K_LT, 1'b0);
    check("edge_clamp.x", int'(x2), 0);
    check("edge_clamp.mov", int'(m2), 0);
    frame(K_NONE, K_LT, 1'b0);
    check("edge_clamp2.x", int'(x2), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
